sys_arr_tile_sched: RTL and testbench

//  Schedules block-matrix multiply traffic for the systolic array. On start, walks output row blocks i,

---
 rtl/proc_pipe_pckg.sv | 37 +++
 rtl/sys_arr_sched_cnt.sv | 26 ++
 rtl/sys_arr_tile_sched.sv | 182 ++++++++++++++++++
 tb/tb_sys_arr_tile_sched.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_pipe_pckg.sv
// Shared processing-pipe types: data-vector kinds, scheduler state encoding and the
// fetch command record produced by the systolic-array tile scheduler.
package proc_pipe_pckg;

   localparam int SCHED_DIM_WDT = 16;

   typedef enum logic [2:0] {
      BATCH_NORM_PARAM = 3'd0,
      ACC_BIAS         = 3'd1,
      STAT             = 3'd2,
      MOV              = 3'd3
   } pipe_data_vect_type_t;

   // State codes kept as plain constants so legacy decode logic can compare raw bits
   typedef logic [2:0] sys_arr_sched_state_t;
   localparam sys_arr_sched_state_t ST_IDLE = 3'd0;
   localparam sys_arr_sched_state_t ST_BN   = 3'd1;
   localparam sys_arr_sched_state_t ST_BIAS = 3'd2;
   localparam sys_arr_sched_state_t ST_STAT = 3'd3;
   localparam sys_arr_sched_state_t ST_MOV  = 3'd4;
   localparam sys_arr_sched_state_t ST_DONE = 3'd5;

   typedef struct packed {
      pipe_data_vect_type_t     vtype;
      logic [SCHED_DIM_WDT-1:0] i;
      logic [SCHED_DIM_WDT-1:0] k;
      logic [SCHED_DIM_WDT-1:0] idx;
      logic                     last_blk;
      logic                     end_xfer;
   } sys_arr_cmd_t;

   // Entry state of every output row block
   function automatic sys_arr_sched_state_t first_row_state(input logic bn, input logic bias);
      return bn ? ST_BN : (bias ? ST_BIAS : ST_STAT);
   endfunction

endpackage

// File: rtl/sys_arr_sched_cnt.sv
// Wrapping index counter: counts 0..limit-1 on clk_en, wrap flags the terminal count.
module sys_arr_sched_cnt #(
   parameter int WDT = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clk_en,
   input  logic           clr,
   input  logic [WDT-1:0] limit,
   output logic [WDT-1:0] cnt,
   output logic           wrap
);

   // Compare against limit-1 so a full-scale limit never overflows the counter
   assign wrap = (cnt == limit - WDT'(1));

   // NOTE: reset is synchronous here, so it sits inside the clocked branch, and
   // sequential state is only ever written with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (!rst_n || clr)
         cnt <= '0;
      else if (clk_en)
         cnt <= wrap ? '0 : cnt + WDT'(1);
   end

endmodule

// File: rtl/sys_arr_tile_sched.sv
// Systolic-array tile scheduler: walks row blocks i, inner blocks k and vector indices,
// issuing one fetch command per vector over a valid/ready handshake.
module sys_arr_tile_sched
   import proc_pipe_pckg::*;
#(
   parameter int VECT_WDT    = 8,
   parameter int DIM_WDT     = SCHED_DIM_WDT,
   parameter int BN_VECT_CNT = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               start,
   input  logic [DIM_WDT-1:0] m_blk_cnt,
   input  logic [DIM_WDT-1:0] k_blk_cnt,
   input  logic [DIM_WDT-1:0] n_vect_cnt,
   input  logic               bias_en,
   input  logic               repl_bias,
   input  logic               bn_en,
   output logic               busy,
   output logic               done,
   output logic               arr_start,
   output logic               cmd_val,
   input  logic               cmd_rdy,
   output logic [2:0]         cmd_type,
   output logic [DIM_WDT-1:0] cmd_i,
   output logic [DIM_WDT-1:0] cmd_k,
   output logic [DIM_WDT-1:0] cmd_idx,
   output logic               cmd_last,
   output logic               cmd_end
);

   sys_arr_sched_state_t state;
   logic [DIM_WDT-1:0]   m_q, k_q, n_q;
   logic                 bias_q, repl_q, bn_q;
   logic                 arr_start_q;

   logic [DIM_WDT-1:0]   i_cnt, k_cnt, idx_cnt, aux_cnt;
   logic                 i_wrap, k_wrap, idx_wrap, aux_wrap;
   logic [DIM_WDT-1:0]   idx_lim, aux_lim;
   logic                 accept, zero_dim, hs, in_aux, in_blk;
   logic                 aux_en, idx_en, k_en, i_en, cnt_clr;
   sys_arr_cmd_t         cmd;

   assign accept   = (state == ST_IDLE) && start;
   assign zero_dim = (m_blk_cnt == '0) || (k_blk_cnt == '0) || (n_vect_cnt == '0);
   assign in_aux   = (state == ST_BN) || (state == ST_BIAS);
   assign in_blk   = (state == ST_STAT) || (state == ST_MOV);

   assign cmd_val  = in_aux || in_blk;
   assign busy     = cmd_val;
   assign done     = (state == ST_DONE);
   assign arr_start = arr_start_q;
   assign hs       = cmd_val && cmd_rdy;

   // idx walks stationary rows then moving columns; aux walks BN params then bias vectors
   assign idx_lim = (state == ST_STAT) ? DIM_WDT'(VECT_WDT) : n_q;
   assign aux_lim = (state == ST_BN) ? DIM_WDT'(BN_VECT_CNT) : (repl_q ? DIM_WDT'(1) : n_q);

   assign aux_en  = hs && in_aux;
   assign idx_en  = hs && in_blk;
   assign k_en    = hs && (state == ST_MOV) && idx_wrap;
   assign i_en    = k_en && k_wrap;
   assign cnt_clr = clear || accept;

   sys_arr_sched_cnt #(.WDT(DIM_WDT)) u_i_cnt (
      .clk(clk), .rst_n(rst_n), .clk_en(i_en), .clr(cnt_clr),
      .limit(m_q), .cnt(i_cnt), .wrap(i_wrap)
   );

   sys_arr_sched_cnt #(.WDT(DIM_WDT)) u_k_cnt (
      .clk(clk), .rst_n(rst_n), .clk_en(k_en), .clr(cnt_clr),
      .limit(k_q), .cnt(k_cnt), .wrap(k_wrap)
   );

   sys_arr_sched_cnt #(.WDT(DIM_WDT)) u_idx_cnt (
      .clk(clk), .rst_n(rst_n), .clk_en(idx_en), .clr(cnt_clr),
      .limit(idx_lim), .cnt(idx_cnt), .wrap(idx_wrap)
   );

   sys_arr_sched_cnt #(.WDT(DIM_WDT)) u_aux_cnt (
      .clk(clk), .rst_n(rst_n), .clk_en(aux_en), .clr(cnt_clr),
      .limit(aux_lim), .cnt(aux_cnt), .wrap(aux_wrap)
   );

   // clear shares the reset path so an aborted schedule never reaches DONE
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         state       <= ST_IDLE;
         arr_start_q <= 1'b0;
         m_q         <= '0;
         k_q         <= '0;
         n_q         <= '0;
         bias_q      <= 1'b0;
         repl_q      <= 1'b0;
         bn_q        <= 1'b0;
      end else begin
         arr_start_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  m_q    <= m_blk_cnt;
                  k_q    <= k_blk_cnt;
                  n_q    <= n_vect_cnt;
                  bias_q <= bias_en;
                  repl_q <= repl_bias;
                  bn_q   <= bn_en;
                  if (zero_dim) begin
                     state <= ST_DONE;
                  end else begin
                     arr_start_q <= 1'b1;
                     state       <= first_row_state(bn_en, bias_en);
                  end
               end
            end
            ST_BN:
               if (hs && aux_wrap)
                  state <= bias_q ? ST_BIAS : ST_STAT;
            ST_BIAS:
               if (hs && aux_wrap)
                  state <= ST_STAT;
            ST_STAT:
               if (hs && idx_wrap)
                  state <= ST_MOV;
            ST_MOV: begin
               if (hs && idx_wrap) begin
                  if (!k_wrap)
                     state <= ST_STAT;
                  else if (i_wrap)
                     state <= ST_DONE;
                  else
                     state <= first_row_state(bn_q, bias_q);
               end
            end
            ST_DONE:
               state <= ST_IDLE;
            default:
               state <= ST_IDLE;
         endcase
      end
   end

   // NOTE: every field gets a default before the case so no latch is inferred.
   always_comb begin
      cmd = '0;
      case (state)
         ST_BN: begin
            cmd.vtype = BATCH_NORM_PARAM;
            cmd.i     = i_cnt;
            cmd.idx   = aux_cnt;
         end
         ST_BIAS: begin
            cmd.vtype = ACC_BIAS;
            cmd.i     = i_cnt;
            cmd.idx   = aux_cnt;
         end
         ST_STAT: begin
            cmd.vtype = STAT;
            cmd.i     = i_cnt;
            cmd.k     = k_cnt;
            cmd.idx   = idx_cnt;
         end
         ST_MOV: begin
            cmd.vtype    = MOV;
            cmd.i        = i_cnt;
            cmd.k        = k_cnt;
            cmd.idx      = idx_cnt;
            cmd.last_blk = idx_wrap && k_wrap;
            cmd.end_xfer = idx_wrap && k_wrap && i_wrap;
         end
         default: cmd = '0;
      endcase
   end

   assign cmd_type = cmd.vtype;
   assign cmd_i    = cmd.i;
   assign cmd_k    = cmd.k;
   assign cmd_idx  = cmd.idx;
   assign cmd_last = cmd.last_blk;
   assign cmd_end  = cmd.end_xfer;

endmodule

// File: tb/tb_sys_arr_tile_sched.sv
// Scoreboard bench for sys_arr_tile_sched: expected commands are queued at stimulus time
// and a negedge monitor pops and compares each accepted or stalled command.
module tb_sys_arr_tile_sched;
   import proc_pipe_pckg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic [15:0] m_blk_cnt = '0, k_blk_cnt = '0, n_vect_cnt = '0;
   logic        bias_en = 1'b0, repl_bias = 1'b0, bn_en = 1'b0;
   logic        busy, done, arr_start, cmd_val;
   logic        cmd_rdy = 1'b0;
   logic [2:0]  cmd_type;
   logic [15:0] cmd_i, cmd_k, cmd_idx;
   logic        cmd_last, cmd_end;

   sys_arr_tile_sched dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .start(start),
      .m_blk_cnt(m_blk_cnt), .k_blk_cnt(k_blk_cnt), .n_vect_cnt(n_vect_cnt),
      .bias_en(bias_en), .repl_bias(repl_bias), .bn_en(bn_en),
      .busy(busy), .done(done), .arr_start(arr_start),
      .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_type(cmd_type),
      .cmd_i(cmd_i), .cmd_k(cmd_k), .cmd_idx(cmd_idx),
      .cmd_last(cmd_last), .cmd_end(cmd_end)
   );

   always #5 clk = ~clk;

   int           pass_cnt = 0;
   int           chk_cnt  = 0;
   int           cyc      = 0;
   sys_arr_cmd_t exp_q[$];
   int           last_pos[$];
   int           n_hs, done_cnt, arr_cnt, last_hs_cyc, done_cyc, acc_cyc;
   bit           done_seen;
   sys_arr_cmd_t act, exp_c;

   task automatic check(input string name, input logic ok, input logic [63:0] got, input logic [63:0] want);
      chk_cnt++;
      if (ok === 1'b1) pass_cnt++;
      else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
   endtask

   function automatic sys_arr_cmd_t mk(input pipe_data_vect_type_t t, input int i, input int k,
                                       input int idx, input bit l, input bit e);
      sys_arr_cmd_t c;
      c.vtype = t; c.i = 16'(i); c.k = 16'(k); c.idx = 16'(idx);
      c.last_blk = l; c.end_xfer = e;
      return c;
   endfunction

   // Expected order: BN params, bias vectors, then per k 8 stationary rows and N moving columns
   task automatic push_case(input int m, input int k, input int n, input bit bias, input bit repl, input bit bn);
      for (int i = 0; i < m; i++) begin
         if (bn) for (int b = 0; b < 2; b++) exp_q.push_back(mk(BATCH_NORM_PARAM, i, 0, b, 0, 0));
         if (bias) for (int j = 0; j < (repl ? 1 : n); j++) exp_q.push_back(mk(ACC_BIAS, i, 0, j, 0, 0));
         for (int kk = 0; kk < k; kk++) begin
            for (int r = 0; r < 8; r++) exp_q.push_back(mk(STAT, i, kk, r, 0, 0));
            for (int c = 0; c < n; c++)
               exp_q.push_back(mk(MOV, i, kk, c, (kk == k-1) && (c == n-1),
                                  (kk == k-1) && (c == n-1) && (i == m-1)));
         end
      end
   endtask

   task automatic clr_stats();
      n_hs = 0; done_cnt = 0; arr_cnt = 0; last_hs_cyc = -1; done_cyc = -1;
      done_seen = 1'b0; last_pos.delete();
   endtask

   always @(posedge clk) cyc++;

   // Monitor: accepted commands pop the scoreboard, stalled ones must already match its head
   always @(negedge clk) begin
      if (cmd_val === 1'b1) begin
         act.vtype = pipe_data_vect_type_t'(cmd_type);
         act.i = cmd_i; act.k = cmd_k; act.idx = cmd_idx;
         act.last_blk = cmd_last; act.end_xfer = cmd_end;
         if (exp_q.size() == 0) begin
            check("cmd_unexpected", 1'b0, 64'(act), 64'd0);
         end else if (cmd_rdy === 1'b1) begin
            exp_c = exp_q.pop_front();
            check("cmd", act == exp_c, 64'(act), 64'(exp_c));
            n_hs++;
            last_hs_cyc = cyc;
            if (cmd_last) last_pos.push_back(n_hs);
         end else begin
            check("cmd_stall_hold", act == exp_q[0], 64'(act), 64'(exp_q[0]));
         end
      end
      if (done === 1'b1) begin
         done_cnt++; done_cyc = cyc; done_seen = 1'b1;
         check("busy_low_at_done", busy == 1'b0, 64'(busy), 64'd0);
      end
      if (arr_start === 1'b1) arr_cnt++;
   end

   task automatic run_case(input int m, input int k, input int n, input bit bias, input bit repl,
                           input bit bn, input bit stall, input bit extra_start, input int exp_cnt);
      bit zero;
      zero = (m == 0) || (k == 0) || (n == 0);
      clr_stats();
      push_case(m, k, n, bias, repl, bn);
      @(posedge clk); #1;
      m_blk_cnt = 16'(m); k_blk_cnt = 16'(k); n_vect_cnt = 16'(n);
      bias_en = bias; repl_bias = repl; bn_en = bn;
      start = 1'b1; cmd_rdy = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; acc_cyc = cyc;
      // Config is registered on accept, so scrambling the inputs must not matter
      m_blk_cnt = 16'd7; k_blk_cnt = 16'd7; n_vect_cnt = 16'd7; bn_en = ~bn;
      check("busy_after_accept", busy == !zero, 64'(busy), 64'(!zero));
      check("arr_start_after_accept", arr_start == !zero, 64'(arr_start), 64'(!zero));
      check("cmd_val_after_accept", cmd_val == !zero, 64'(cmd_val), 64'(!zero));
      if (zero) check("done_after_zero_accept", done == 1'b1, 64'(done), 64'd1);
      for (int c = 0; c < 4000 && !done_seen; c++) begin
         cmd_rdy = stall ? ((c % 9) >= 3 && $urandom_range(0, 3) != 0) : 1'b1;
         start = extra_start && (c == 6);
         @(posedge clk); #1;
         start = 1'b0;
      end
      check("done_within_budget", done_seen, 64'(done_seen), 64'd1);
      @(posedge clk); #1;
      check("queue_drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
      check("cmd_count", n_hs == exp_cnt, 64'(n_hs), 64'(exp_cnt));
      check("done_pulse_count", done_cnt == 1, 64'(done_cnt), 64'd1);
      check("arr_start_count", arr_cnt == (zero ? 0 : 1), 64'(arr_cnt), 64'(zero ? 0 : 1));
      if (zero) check("zero_done_timing", done_cyc == acc_cyc, 64'(done_cyc), 64'(acc_cyc));
      else check("done_after_last_hs", done_cyc == last_hs_cyc + 1, 64'(done_cyc), 64'(last_hs_cyc + 1));
      check("idle_after_done", busy == 1'b0 && cmd_val == 1'b0, 64'({busy, cmd_val}), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      clr_stats();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_busy", busy == 1'b0, 64'(busy), 64'd0);
      check("rst_done", done == 1'b0, 64'(done), 64'd0);
      check("rst_arr_start", arr_start == 1'b0, 64'(arr_start), 64'd0);
      check("rst_cmd_val", cmd_val == 1'b0, 64'(cmd_val), 64'd0);
      check("rst_cmd_fields", {cmd_type, cmd_i, cmd_k, cmd_idx, cmd_last, cmd_end} == '0,
            64'({cmd_type, cmd_i, cmd_k, cmd_idx, cmd_last, cmd_end}), 64'd0);

      // M=1 K=1 N=3: 8 STAT + 3 MOV, last/end on the 11th
      run_case(1, 1, 3, 0, 0, 0, 0, 0, 11);
      check("case1_last_pos", last_pos.size() == 1 && last_pos[0] == 11, 64'(last_pos.size()), 64'd11);

      // M=2 K=2 N=4, replicated bias: 25 per row block
      run_case(2, 2, 4, 1, 1, 0, 0, 0, 50);
      check("case2_last_pos", last_pos.size() == 2 && last_pos[0] == 25 && last_pos[1] == 50,
            64'(last_pos.size() > 0 ? last_pos[0] : -1), 64'd25);

      // M=1 K=1 N=2 with BN and full bias: 2+2+8+2
      run_case(1, 1, 2, 1, 0, 1, 0, 0, 14);

      // Case 2 again under ready stalls, with a start pulse issued mid-run
      run_case(2, 2, 4, 1, 1, 0, 1, 1, 50);
      check("case2_stall_last_pos", last_pos.size() == 2 && last_pos[0] == 25 && last_pos[1] == 50,
            64'(last_pos.size() > 0 ? last_pos[0] : -1), 64'd25);

      // Zero inner-block count: no commands, done right after accept
      run_case(1, 0, 3, 0, 0, 0, 0, 0, 0);

      // start coincident with clear is dropped
      clr_stats();
      @(posedge clk); #1;
      m_blk_cnt = 16'd1; k_blk_cnt = 16'd1; n_vect_cnt = 16'd1;
      start = 1'b1; clear = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; clear = 1'b0;
      check("clear_beats_start_busy", busy == 1'b0, 64'(busy), 64'd0);
      check("clear_beats_start_arr", arr_start == 1'b0, 64'(arr_start), 64'd0);
      repeat (3) @(posedge clk);
      #1 check("clear_beats_start_no_done", done_cnt == 0, 64'(done_cnt), 64'd0);

      // Abort after the 5th handshake, then replay from scratch
      clr_stats();
      push_case(1, 1, 3, 0, 0, 0);
      @(posedge clk); #1;
      m_blk_cnt = 16'd1; k_blk_cnt = 16'd1; n_vect_cnt = 16'd3;
      bias_en = 1'b0; repl_bias = 1'b0; bn_en = 1'b0;
      start = 1'b1; cmd_rdy = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 200 && n_hs < 5; c++) begin
         @(posedge clk); #1;
      end
      check("abort_reached_5", n_hs == 5, 64'(n_hs), 64'd5);
      clear = 1'b1; cmd_rdy = 1'b0;
      @(posedge clk); #1;
      clear = 1'b0;
      check("abort_cmd_val", cmd_val == 1'b0, 64'(cmd_val), 64'd0);
      check("abort_busy", busy == 1'b0, 64'(busy), 64'd0);
      repeat (4) @(posedge clk);
      #1 check("abort_no_done", done_cnt == 0, 64'(done_cnt), 64'd0);
      exp_q.delete();
      run_case(1, 1, 3, 0, 0, 0, 0, 0, 11);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
